// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: ready/valid byte input, LSB-first serial output, registered line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_transmitter #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE      = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME    = CPU_CLOCK_FREQ / BAUD_RATE;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] TIMER_LAST =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                         state;
    logic [CLOCK_COUNTER_WIDTH-1:0] timer;
    logic [2:0]                     bit_idx;
    logic [7:0]                     shift_reg;

    // The line value for each symbol is loaded on the same edge that enters
    // that symbol, so serial_out changes in lockstep with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b0;
            timer         <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    if (data_in_valid && data_in_ready) begin
                        shift_reg     <= data_in;
                        state         <= START;
                        timer         <= '0;
                        bit_idx       <= '0;
                        serial_out    <= 1'b0;
                        data_in_ready <= 1'b0;
                    end else begin
                        data_in_ready <= 1'b1;
                    end
                end
                START: begin
                    if (timer == TIMER_LAST) begin
                        timer      <= '0;
                        state      <= DATA;
                        serial_out <= shift_reg[0];
                    end else begin
                        timer <= timer + CLOCK_COUNTER_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (timer == TIMER_LAST) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= ^shift_reg;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + CLOCK_COUNTER_WIDTH'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (timer == TIMER_LAST) begin
                        timer      <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        timer <= timer + CLOCK_COUNTER_WIDTH'(1);
                    end
                end
`endif
                STOP: begin
                    serial_out <= 1'b1;
                    if (timer == TIMER_LAST) begin
                        timer         <= '0;
                        state         <= IDLE;
                        data_in_ready <= 1'b1;
                    end else begin
                        timer <= timer + CLOCK_COUNTER_WIDTH'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    serial_out    <= 1'b1;
                    data_in_ready <= 1'b0;
                    timer         <= '0;
                    bit_idx       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus queues expected bytes, a line monitor
// decodes frames independently and compares bit values, bit timing and frame spacing.
module tb_uart_transmitter;

    localparam int S = 50_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * S;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;

    int         tests = 0;
    int         failures = 0;
    int         cycle = 0;
    int         frames_pushed = 0;
    int         frames_decoded = 0;
    logic [7:0] expected_q[$];
    int         start_times[$];

    uart_transmitter #(
        .CPU_CLOCK_FREQ(50_000_000),
        .BAUD_RATE     (115_200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Samples every cycle of every symbol: the mid-bit sample gives the value,
    // any change within a symbol counts as a timing error.
    task automatic decode_frame();
        logic [NBITS-1:0] line_bits;
        logic             first;
        int               unstable = 0;
        logic [7:0]       got_byte;
        logic [7:0]       exp_byte;
        line_bits = '0;
        first = 1'b0;
        start_times.push_back(cycle);
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < S; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (rst !== 1'b1) return;
                if (c == 0) first = serial_out;
                else if (serial_out !== first) unstable++;
                if (c == S / 2) line_bits[k] = serial_out;
            end
        end
        frames_decoded++;
        checkOutput("bit_timing", unstable, 0);
        checkOutput("start_bit", {31'd0, line_bits[0]}, 0);
        checkOutput("stop_bit", {31'd0, line_bits[NBITS-1]}, 1);
        got_byte = line_bits[8:1];
        if (expected_q.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_frame: got byte %02h, required no frame", got_byte);
        end else begin
            exp_byte = expected_q.pop_front();
            checkOutput("data_byte", {24'd0, got_byte}, {24'd0, exp_byte});
`ifdef UART_TX_PARITY_EN
            checkOutput("parity_bit", {31'd0, line_bits[9]}, $countones(exp_byte) % 2);
`endif
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && serial_out === 1'b0) decode_frame();
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [7:0] b, input bit keep_valid,
                                 input bit expect_frame, output int acc_cycle);
        int waited = 0;
        data_in = b;
        data_in_valid = 1'b1;
        while (data_in_ready !== 1'b1 && waited < 12 * S) begin
            @(negedge clk);
            waited++;
        end
        if (data_in_ready !== 1'b1) begin
            tests++;
            failures++;
            $display("[TB] FAIL accept_timeout: ready=%b after %0d cycles, required 1", data_in_ready, waited);
            data_in_valid = 1'b0;
            acc_cycle = cycle;
            return;
        end
        if (expect_frame) begin
            expected_q.push_back(b);
            frames_pushed++;
        end
        @(posedge clk);
        @(negedge clk);
        acc_cycle = cycle;
        checkOutput("ready_drop", {31'd0, data_in_ready}, 0);
        if (!keep_valid) data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int acc_cycle, input string name);
        int waited = 0;
        while (data_in_ready !== 1'b1 && waited < 12 * S) begin
            @(negedge clk);
            waited++;
        end
        if (data_in_ready !== 1'b1) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: ready never returned, required 1 after %0d cycles", name, FRAME);
        end else begin
            checkOutput(name, cycle - acc_cycle, FRAME);
        end
    endtask

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int acc;
        int acc2;
        int lows;
        logic [7:0] rb;

        rst = 1'b0;
        data_in = 8'h99;
        data_in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_line", {31'd0, serial_out}, 1);
            checkOutput("reset_ready", {31'd0, data_in_ready}, 0);
        end
        rst = 1'b1;
        data_in_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_release", {31'd0, data_in_ready}, 1);

        applyStimulus(8'h41, 1'b0, 1'b1, acc);
        wait_idle(acc, "frame_len_41");

        applyStimulus(8'hA5, 1'b0, 1'b1, acc);
        data_in = 8'hFF;
        repeat (1000) @(negedge clk);
        data_in_valid = 1'b1;
        repeat (1000) @(negedge clk);
        data_in_valid = 1'b0;
        wait_idle(acc, "frame_len_a5");
        lows = 0;
        repeat (2 * S) begin
            @(negedge clk);
            if (serial_out !== 1'b1) lows++;
        end
        checkOutput("no_second_frame", lows, 0);

        start_times.delete();
        applyStimulus(8'h55, 1'b1, 1'b1, acc);
        applyStimulus(8'hAA, 1'b0, 1'b1, acc2);
        checkOutput("b2b_accept_spacing", acc2 - acc, FRAME + 1);
        wait_idle(acc2, "frame_len_aa");
        if (start_times.size() >= 2) begin
            checkOutput("b2b_line_gap", start_times[1] - start_times[0] - (NBITS - 1) * S, S + 1);
        end else begin
            tests++;
            failures++;
            $display("[TB] FAIL b2b_line_gap: saw %0d start bits, required 2", start_times.size());
        end

        applyStimulus(8'h00, 1'b0, 1'b0, acc);
        repeat (4 * S + S / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midframe_reset_line", {31'd0, serial_out}, 1);
        checkOutput("midframe_reset_ready", {31'd0, data_in_ready}, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midframe_release_ready", {31'd0, data_in_ready}, 1);
        applyStimulus(8'h3C, 1'b0, 1'b1, acc);
        wait_idle(acc, "frame_len_3c");

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            applyStimulus(rb, 1'b0, 1'b1, acc);
            wait_idle(acc, "frame_len_random");
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

`ifdef UART_TX_PARITY_EN
        applyStimulus(8'h07, 1'b0, 1'b1, acc);
        wait_idle(acc, "frame_len_parity_07");
        applyStimulus(8'h03, 1'b0, 1'b1, acc);
        wait_idle(acc, "frame_len_parity_03");
`endif

        repeat (2 * S) @(negedge clk);
        checkOutput("queue_drained", expected_q.size(), 0);
        checkOutput("frame_count", frames_decoded, frames_pushed);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial transmit side of the Riscv151 UART, driving FPGA_SERIAL_TX.
- Accepts one byte per ready/valid handshake from the CPU's memory-mapped UART control path.
- Serializes it as 8N1: one start bit, 8 data bits LSB first, one stop bit.
- Bit timing is derived from the CPU clock.
- Pairs with the existing receive path on FPGA_SERIAL_RX, so simulation benches and on-board serial loopback exercise both ends.

Parameters:
CPU_CLOCK_FREQ, 50_000_000, clk frequency in Hz
BAUD_RATE, 115_200, serial bit rate
SYMBOL_EDGE_TIME (localparam), CPU_CLOCK_FREQ / BAUD_RATE (integer truncation; 434 at defaults), clk cycles per bit
CLOCK_COUNTER_WIDTH (localparam), $clog2(SYMBOL_EDGE_TIME), bit-timer width

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising clk edge resets the block)
data_in  input  8  byte to transmit; sampled only on the accepting edge
data_in_valid  input  1  producer has a byte
data_in_ready  output  1  block can accept a byte this cycle
serial_out  output  1  UART line (FPGA_SERIAL_TX); idle high

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, serial_out=1, data_in_ready=0 while rst is held low, bit timer=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame. The line returns high on the next edge with no partial stop bit.
- First cycle after rst rises: data_in_ready=1.
- States: IDLE -> START -> DATA -> STOP -> IDLE (PARITY between DATA and STOP only with the optional feature).
- IDLE:
  - serial_out=1, data_in_ready=1.
  - Accept occurs when data_in_valid && data_in_ready at a rising edge: latch data_in into the shift register, go to START, clear the timer.
- data_in_ready is a registered/state decode: 1 only in IDLE. It drops in the cycle after the accept.
- START: serial_out=0 for exactly SYMBOL_EDGE_TIME cycles, beginning the cycle after the accept.
- DATA:
  - serial_out = current data bit, bit 0 first.
  - Each bit is held SYMBOL_EDGE_TIME cycles.
  - The bit index advances 0..7 when the timer hits SYMBOL_EDGE_TIME-1.
  - After bit 7, go to STOP.
- STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles, then IDLE.
- Timer: counts 0..SYMBOL_EDGE_TIME-1, resets to 0 on every state/bit change. No drift is allowed across bits.
- Frame length: accept edge to IDLE re-entry is exactly 10*SYMBOL_EDGE_TIME cycles (4340 at defaults).
- Back-to-back frames:
  - If valid is held, the next accept happens on the first IDLE cycle.
  - The line is therefore high for SYMBOL_EDGE_TIME+1 cycles between frames; the stop bit is never shortened.
- data_in and data_in_valid changes outside IDLE are ignored. The latched byte is immutable for the whole frame.
- No glitches: serial_out is driven from a flop, never combinationally from inputs.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - After data bit 7, a PARITY state drives even parity (XOR of the 8 latched data bits) for SYMBOL_EDGE_TIME cycles, then STOP.
  - Frame = 11*SYMBOL_EDGE_TIME cycles.
- Undefined:
  - No PARITY state and no parity logic are synthesized.
  - Frame = 10*SYMBOL_EDGE_TIME, 8N1 exactly.

Test Plan:
- Reset: hold rst=0 for 3 cycles with data_in_valid=1 -> serial_out=1 and data_in_ready=0 throughout; the cycle after rst=1, data_in_ready=1.
- Single byte 0x41:
  - Stimulus: pulse valid for one cycle.
  - Start bit low for 434 cycles, then sample mid-bit.
  - Required: 1,0,0,0,0,0,1,0 (LSB first), stop high for 434 cycles, data_in_ready back to 1 exactly 4340 cycles after the accept.
- Data stability: accept 0xA5, then change data_in to 0xFF and toggle valid mid-frame -> decoded byte is 0xA5, no second frame starts.
- Back-to-back: hold valid with 0x55 then 0xAA -> two frames decoded 0x55, 0xAA; line high exactly 435 cycles between the last data bit of frame 1 and the start bit of frame 2.
- Reset mid-frame: rst=0 during data bit 3 of 0x00 -> serial_out=1 next edge; after release, a fresh 0x3C transmits and decodes correctly.
- UART_TX_PARITY_EN defined:
  - 0x07 -> parity bit 1 for 434 cycles; 0x03 -> parity bit 0.
  - Frame = 4774 cycles (11 bits).
